stream_upsizer: RTL and testbench
=================================

// Module: stream_upsizer
// PURPOSE
//  Valid/ready width upsizer placed directly downstream of single_stage_pipeline_reg.
//  Packs RATIO consecutive IN_WIDTH-bit words into one registered output beat.
//  An optional in_last closes a beat early, producing a partial beat with a lane keep mask.
//  Sustains full input rate (one word/cycle) while out_ready=1.
// PARAMETERS
//  IN_WIDTH   32   width of one input word (one lane)
//  RATIO      2    input words per output beat; legal range >=2
//  OUT_WIDTH  -    localparam = IN_WIDTH*RATIO
//  CNT_W      -    localparam = $clog2(RATIO)
// PORTS
//  clk        in   1          single clock; all state updates on its rising edge
//  resetn     in   1          reset, synchronous, active-low
//  in_valid   in   1          upstream word valid
//  in_ready   out  1          upstream may transfer (in_valid&&in_ready = accept)
//  in_data    in   IN_WIDTH   input word
//  in_last    in   1          word is last of packet; closes the current beat
//  out_valid  out  1          output beat valid
//  out_ready  in   1          downstream accepts beat
//  out_data   out  OUT_WIDTH  packed beat; lane k = bits [k*IN_WIDTH +: IN_WIDTH]
//  out_keep   out  RATIO      bit k=1 when lane k holds a written word
//  out_last   out  1          beat ends a packet
// BEHAVIOUR
//  - Reset (resetn=0 at a clk edge): out_valid=0, out_data=0, out_keep=0, out_last=0, lane count=0.
//    in_ready=0 while resetn=0. Reset mid-beat discards all accepted partial lanes.
//  - in_ready = resetn && (!out_valid || out_ready); combinational, no dependence on in_valid.
//  - Accept: word goes to lane[count]; keep[count] set; count increments.
//  - Beat closes when count==RATIO-1 or in_last=1 on the accepted word.
//    out_valid=1 the cycle after the closing word is accepted (latency 1); count returns to 0.
//  - out_last = in_last of the closing word (0 for a full beat without in_last).
//  - Unwritten lanes of a partial beat read 0 with keep bit 0. in_last on lane 0 gives keep=1'b1 in bit 0 only.
//  - Transfer: out_valid && out_ready drops out_valid unless a closing word is accepted the same cycle.
//  - Same-cycle transfer + accept: the beat leaves, and the new word is written to lane 0 of a fresh beat.
//    out_data/out_keep are cleared except for that lane.
//  - Stall (out_valid && !out_ready): out_data, out_keep and out_last are held bit-stable.
//    in_ready=0; in_valid is ignored and nothing is lost.
//  - While out_valid=0, out_data is the partial assembly. Unwritten lanes are 0; downstream ignores it.
//  - No internal FIFO; word order is strictly preserved; no data created or dropped except on reset.
// STRUCTURE
//  - Single module, roughly 150-250 lines: count register, beat data/keep/last registers, valid flag.
//  - No sub-module. Output register doubles as assembly register; no pipeline_reg instance.
//  - Shared package/include stream_defs: default IN_WIDTH=32 and a clog2 helper for CNT_W.
//    Keep semantics (bit per lane, LSB = first word) are common to all stream blocks.
// TESTING  (IN_WIDTH=32, RATIO=2)
//  1. Reset: hold resetn=0 for 2 cycles.
//     -> out_valid=0, out_keep=0, in_ready=0; after release with out_valid=0, in_ready=1.
//  2. out_ready=1; send 0x11 then 0x22 back-to-back.
//     -> next cycle out_valid=1, out_data=0x00000022_00000011, keep=2'b11, last=0; in_ready never drops.
//  3. Send 0x33 with in_last=1 at lane 0.
//     -> out_data=0x00000000_00000033, keep=2'b01, last=1.
//  4. Beat 0x0A,0x0B with out_ready=0; hold in_valid=1 with 0x0C for 3 cycles.
//     -> in_ready=0; out_data=0x0000000B_0000000A stable all 3 cycles.
//     Raise out_ready: beat transfers, 0x0C accepted the same cycle into lane 0.
//  5. Accept 0x44, pulse resetn=0 for 1 cycle, then send 0x55,0x66.
//     -> single beat 0x00000066_00000055, keep=2'b11; 0x44 never appears.
//  6. Stream 8 words 1..8 with out_ready=1, last on word 8.
//     -> 4 beats {2,1},{4,3},{6,5},{8,7}; in_ready continuously 1; out_last only on the 4th beat.

Source files
------------

// File: rtl/stream_upsizer_pkg.sv
// Shared stream definitions: default lane width and a clog2 helper for counter sizing.
// Latency: n/a (package only).
// Backpressure: n/a. Keep convention for all stream blocks: one bit per lane, LSB = first word.
package stream_upsizer_pkg;

    localparam int DEF_IN_WIDTH = 32;
    localparam int DEF_RATIO    = 2;

    // Smallest r with 2**r >= v; callers guarantee v >= 2 so the result is >= 1.
    function automatic int clog2_f(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/stream_upsizer.sv
// Valid/ready width upsizer: packs RATIO input words into one registered output beat.
// Latency: 1 cycle from acceptance of the closing word to out_valid.
// Backpressure: in_ready = resetn && (!out_valid || out_ready); a stalled beat is held bit-stable.
//
// Ports:
//   clk, resetn          clock, synchronous active-low reset
//   in_valid/in_ready    upstream handshake; in_data is one lane, in_last closes the beat early
//   out_valid/out_ready  downstream handshake
//   out_data/out_keep    packed beat (lane k at [k*IN_WIDTH +: IN_WIDTH]) and per-lane written mask
//   out_last             beat ends a packet
module stream_upsizer
    import stream_upsizer_pkg::*;
#(
    parameter int IN_WIDTH  = DEF_IN_WIDTH,
    parameter int RATIO     = DEF_RATIO,
    localparam int OUT_WIDTH = IN_WIDTH * RATIO,
    localparam int CNT_W     = clog2_f(RATIO)
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic [RATIO-1:0]     out_keep,
    output logic                 out_last
);

    // The output register doubles as the assembly register: while r_vld=0 it
    // holds the partially filled beat, and r_cnt points at the next free lane.
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_vld;
    logic [OUT_WIDTH-1:0] r_data;
    logic [RATIO-1:0]     r_keep;
    logic                 r_last;

    logic                 w_ready;
    logic                 w_accept;
    logic                 w_xfer;
    logic                 w_close;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic                 w_vld_nxt;
    logic [OUT_WIDTH-1:0] w_data_nxt;
    logic [RATIO-1:0]     w_keep_nxt;
    logic                 w_last_nxt;

    assign w_ready  = resetn && (!r_vld || out_ready);
    assign w_accept = in_valid && w_ready;
    assign w_xfer   = r_vld && out_ready;
    assign w_close  = w_accept && ((r_cnt == CNT_W'(RATIO - 1)) || in_last);

    always_comb begin
        w_cnt_nxt  = r_cnt;
        w_vld_nxt  = r_vld;
        w_data_nxt = r_data;
        w_keep_nxt = r_keep;
        w_last_nxt = r_last;

        // A departing beat leaves a clean, empty assembly register behind so
        // unwritten lanes of the next beat read as zero.
        if (w_xfer) begin
            w_vld_nxt  = 1'b0;
            w_data_nxt = '0;
            w_keep_nxt = '0;
            w_last_nxt = 1'b0;
        end

        // When a beat is held, acceptance implies it is also leaving, and r_cnt
        // is already back at 0, so the word lands in lane 0 of the fresh beat.
        if (w_accept) begin
            for (int k = 0; k < RATIO; k++) begin
                if (r_cnt == CNT_W'(k)) begin
                    w_data_nxt[k*IN_WIDTH +: IN_WIDTH] = in_data;
                    w_keep_nxt[k]                      = 1'b1;
                end
            end
            if (w_close) begin
                w_vld_nxt  = 1'b1;
                w_last_nxt = in_last;
                w_cnt_nxt  = '0;
            end else begin
                w_cnt_nxt  = r_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cnt  <= '0;
            r_vld  <= 1'b0;
            r_data <= '0;
            r_keep <= '0;
            r_last <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_vld  <= w_vld_nxt;
            r_data <= w_data_nxt;
            r_keep <= w_keep_nxt;
            r_last <= w_last_nxt;
        end
    end

    assign in_ready  = w_ready;
    assign out_valid = r_vld;
    assign out_data  = r_data;
    assign out_keep  = r_keep;
    assign out_last  = r_last;

endmodule

// File: tb/tb_stream_upsizer.sv
// Directed table-driven bench for stream_upsizer (IN_WIDTH=32, RATIO=2).
// Each row drives one cycle, checks in_ready before the edge and the output registers after it.
// Hand-written tail covers a stalled last-beat and in_ready independence from in_valid.
module tb_stream_upsizer;

    localparam int IW = 32;
    localparam int RT = 2;
    localparam int OW = IW * RT;

    logic          clk = 1'b0;
    logic          resetn;
    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_data;
    logic [RT-1:0] out_keep;
    logic          out_last;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    stream_upsizer #(.IN_WIDTH(IW), .RATIO(RT)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_last  (out_last)
    );

    typedef struct {
        logic          rst_n;
        logic          iv;
        logic [IW-1:0] id;
        logic          il;
        logic          ordy;
        logic          e_ir;
        logic          e_ov;
        logic [OW-1:0] e_od;
        logic [RT-1:0] e_ok;
        logic          e_ol;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic rst_n, input logic iv, input logic [IW-1:0] id,
                       input logic il, input logic ordy, input logic e_ir,
                       input logic e_ov, input logic [IW-1:0] e_hi, input logic [IW-1:0] e_lo,
                       input logic [RT-1:0] e_ok, input logic e_ol);
        vec_t v;
        v.rst_n = rst_n; v.iv = iv; v.id = id; v.il = il; v.ordy = ordy;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = {e_hi, e_lo}; v.e_ok = e_ok; v.e_ol = e_ol;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Called at a falling edge: drive, check combinational in_ready, clock, check registers.
    task automatic step(input string tag, input logic rst_n, input logic iv, input logic [IW-1:0] id,
                        input logic il, input logic ordy, input logic e_ir, input logic e_ov,
                        input logic [OW-1:0] e_od, input logic [RT-1:0] e_ok, input logic e_ol);
        resetn = rst_n; in_valid = iv; in_data = id; in_last = il; out_ready = ordy;
        #1;
        chk({tag, " in_ready"}, OW'(in_ready), OW'(e_ir));
        @(posedge clk);
        #1;
        chk({tag, " out_valid"}, OW'(out_valid), OW'(e_ov));
        chk({tag, " out_data"},  out_data,        e_od);
        chk({tag, " out_keep"},  OW'(out_keep),  OW'(e_ok));
        chk({tag, " out_last"},  OW'(out_last),  OW'(e_ol));
        @(negedge clk);
    endtask

    initial begin
        resetn = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;

        //   rst iv  data   il ordy ir  ov  hi      lo      keep   last
        // reset held 2 cycles, then release idle
        add(0, 0, 32'h0,  0, 1,   0,  0,  32'h0,  32'h0,  2'b00, 0);
        add(0, 0, 32'h0,  0, 1,   0,  0,  32'h0,  32'h0,  2'b00, 0);
        add(1, 0, 32'h0,  0, 1,   1,  0,  32'h0,  32'h0,  2'b00, 0);
        // full beat 0x11,0x22
        add(1, 1, 32'h11, 0, 1,   1,  0,  32'h0,  32'h11, 2'b01, 0);
        add(1, 1, 32'h22, 0, 1,   1,  1,  32'h22, 32'h11, 2'b11, 0);
        // last on lane 0, accepted while previous beat leaves
        add(1, 1, 32'h33, 1, 1,   1,  1,  32'h0,  32'h33, 2'b01, 1);
        // 0x0A lands in lane 0 of a fresh beat as 0x33 leaves
        add(1, 1, 32'h0A, 0, 1,   1,  0,  32'h0,  32'h0A, 2'b01, 0);
        add(1, 1, 32'h0B, 0, 0,   1,  1,  32'h0B, 32'h0A, 2'b11, 0);
        // stall for 3 cycles with 0x0C offered
        add(1, 1, 32'h0C, 0, 0,   0,  1,  32'h0B, 32'h0A, 2'b11, 0);
        add(1, 1, 32'h0C, 0, 0,   0,  1,  32'h0B, 32'h0A, 2'b11, 0);
        add(1, 1, 32'h0C, 0, 0,   0,  1,  32'h0B, 32'h0A, 2'b11, 0);
        // release: beat transfers, 0x0C accepted into lane 0
        add(1, 1, 32'h0C, 0, 1,   1,  0,  32'h0,  32'h0C, 2'b01, 0);
        add(1, 1, 32'h0D, 1, 1,   1,  1,  32'h0D, 32'h0C, 2'b11, 1);
        // accept 0x44 then reset mid-beat discards it
        add(1, 1, 32'h44, 0, 1,   1,  0,  32'h0,  32'h44, 2'b01, 0);
        add(0, 1, 32'h99, 0, 1,   0,  0,  32'h0,  32'h0,  2'b00, 0);
        add(1, 1, 32'h55, 0, 1,   1,  0,  32'h0,  32'h55, 2'b01, 0);
        add(1, 1, 32'h66, 0, 1,   1,  1,  32'h66, 32'h55, 2'b11, 0);
        // stream 1..8, last on 8
        add(1, 1, 32'h1,  0, 1,   1,  0,  32'h0,  32'h1,  2'b01, 0);
        add(1, 1, 32'h2,  0, 1,   1,  1,  32'h2,  32'h1,  2'b11, 0);
        add(1, 1, 32'h3,  0, 1,   1,  0,  32'h0,  32'h3,  2'b01, 0);
        add(1, 1, 32'h4,  0, 1,   1,  1,  32'h4,  32'h3,  2'b11, 0);
        add(1, 1, 32'h5,  0, 1,   1,  0,  32'h0,  32'h5,  2'b01, 0);
        add(1, 1, 32'h6,  0, 1,   1,  1,  32'h6,  32'h5,  2'b11, 0);
        add(1, 1, 32'h7,  0, 1,   1,  0,  32'h0,  32'h7,  2'b01, 0);
        add(1, 1, 32'h8,  1, 1,   1,  1,  32'h8,  32'h7,  2'b11, 1);
        // drain with no new word: assembly register comes back clean
        add(1, 0, 32'h0,  0, 1,   1,  0,  32'h0,  32'h0,  2'b00, 0);

        for (int i = 0; i < vq.size(); i++) begin
            step($sformatf("vec%0d", i), vq[i].rst_n, vq[i].iv, vq[i].id, vq[i].il, vq[i].ordy,
                 vq[i].e_ir, vq[i].e_ov, vq[i].e_od, vq[i].e_ok, vq[i].e_ol);
        end

        // Stalled partial last-beat: held with in_valid toggling, in_ready stays 0 regardless.
        step("stall_load", 1, 1, 32'h77, 1, 0, 1, 1, {32'h0, 32'h77}, 2'b01, 1);
        step("stall_iv1",  1, 1, 32'h88, 0, 0, 0, 1, {32'h0, 32'h77}, 2'b01, 1);
        step("stall_iv0",  1, 0, 32'h88, 0, 0, 0, 1, {32'h0, 32'h77}, 2'b01, 1);
        step("stall_iv1b", 1, 1, 32'h88, 1, 0, 0, 1, {32'h0, 32'h77}, 2'b01, 1);
        // 0x88 was never accepted during the stall; it now takes lane 0 as the beat leaves.
        step("stall_rel",  1, 1, 32'h88, 0, 1, 1, 0, {32'h0, 32'h88}, 2'b01, 0);

        // Bounded wait for the closing beat after offering 0x99 for one cycle.
        resetn = 1'b1; in_valid = 1'b1; in_data = 32'h99; in_last = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        begin
            int waited;
            waited = 0;
            while (!out_valid && waited < 8) begin
                @(posedge clk);
                #1;
                waited++;
            end
            n_tests++;
            if (!out_valid) begin
                n_fail++;
                $display("FAIL wait_beat: out_valid never rose within 8 cycles");
            end
        end
        chk("wait_beat out_data", out_data, {32'h99, 32'h88});
        chk("wait_beat out_keep", OW'(out_keep), OW'(2'b11));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
